// File: rtl/mod_n_ud_counter_if.sv
// Control and status bundle for one modulo-N up/down counter stage.
// The master drives the controls; the slave (counter) returns count and status.
interface mod_n_ud_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up, load, load_val,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output q, tc, wrap, load_err
  );
endinterface

// File: rtl/mod_n_ud_counter.sv
// Modulo-N up/down counter with parallel load, combinational terminal count and wrap/load-error pulses.
// Latency: q, wrap and load_err are registered (1 cycle); tc is combinational. No backpressure: steps whenever en is high.
module mod_n_ud_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 12
) (
  input logic               clk,
  input logic               rst,
  mod_n_ud_counter_if.slave bus
);

  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("mod_n_ud_counter: MOD must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH is representable and every load_val is then legal.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             err_r;
  logic             err_nxt;
  logic             at_max;
  logic             at_zero;
  logic             load_ok;

  always_comb begin
    at_max  = (q_r == MAX_VAL);
    at_zero = (q_r == '0);
    load_ok = ({1'b0, bus.load_val} < MOD_EXT);
  end

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        q_nxt = bus.load_val;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_max) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = q_r + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_nxt    = MAX_VAL;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = q_r - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
      err_r  <= err_nxt;
    end
  end

  // tc looks only at en, not load, so a cascade sees the raw step request of this stage.
  assign bus.tc       = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));
  assign bus.q        = q_r;
  assign bus.wrap     = wrap_r;
  assign bus.load_err = err_r;

endmodule
